// File: rtl/sequential_alu_hs.sv
// Multi-cycle integer ALU (add/sub/mul/div, signed or unsigned) behind a
// valid/ready input handshake. Add/sub finish at the accepting edge, while
// mul/div iterate one bit per clock. Results are full double width: the
// high product half for mul, or the remainder for div.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | ready for a request; add/sub and early exits complete here
//   ITER    | one multiplier/quotient bit per clock, counter W-1 down to 0
//   FIX     | sign correction and overflow evaluation, result published
module sequential_alu_hs #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_op,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic [DATA_WIDTH-1:0] o_r,
    output logic                  o_ovf,
    output logic                  o_dbz
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          accept;
    logic          needs_iter;
    logic [CW-1:0] cnt;

    // Operation context latched at accept
    logic          op_div;
    logic          sgn_mode;
    logic          neg_q;
    logic          neg_r;
    logic [W:0]    mag_a;
    logic [W:0]    mag_b;

    // Iteration registers: hi is the partial product high half or the
    // partial remainder, lo holds the multiplier or dividend as it is
    // shifted out and the product low half or quotient as it is shifted in.
    logic [W:0]    hi;
    logic [W-1:0]  lo;

    logic [W:0]    a_mag_in;
    logic [W:0]    b_mag_in;
    logic [W:0]    sum_ext;
    logic [W:0]    diff_ext;
    logic          add_ovf;
    logic          sub_ovf;
    logic          early_dbz;
    logic          early_ovf;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic [W:0]    hi_nxt;
    logic [W-1:0]  lo_nxt;

    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic           mul_ovf;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;

    // Decode of the incoming request: add/sub results, magnitudes, early exits
    always_comb begin
        sum_ext   = {1'b0, i_a} + {1'b0, i_b};
        diff_ext  = {1'b0, i_a} - {1'b0, i_b};
        add_ovf   = i_signed ? ((i_a[W-1] == i_b[W-1]) && (sum_ext[W-1] != i_a[W-1]))
                             : sum_ext[W];
        sub_ovf   = i_signed ? ((i_a[W-1] != i_b[W-1]) && (diff_ext[W-1] != i_a[W-1]))
                             : diff_ext[W];
        // One extra bit keeps |MIN| exact
        a_mag_in  = (i_signed && i_a[W-1]) ? (~{1'b1, i_a} + (W+1)'(1)) : {1'b0, i_a};
        b_mag_in  = (i_signed && i_b[W-1]) ? (~{1'b1, i_b} + (W+1)'(1)) : {1'b0, i_b};
        early_dbz = (i_b == '0);
        early_ovf = i_signed && (i_a == MIN_VAL) && (i_b == '1);
        needs_iter = (i_op == OP_MUL) || ((i_op == OP_DIV) && !early_dbz && !early_ovf);
    end

    // One shift-add or restoring-division step
    always_comb begin
        mul_sum   = hi + (lo[0] ? mag_a : '0);
        div_shift = {hi[W-1:0], lo[W-1]};
        div_diff  = div_shift - mag_b;
        hi_nxt    = hi;
        lo_nxt    = lo;
        if (op_div) begin
            if (div_shift >= mag_b) begin
                hi_nxt = div_diff;
                lo_nxt = {lo[W-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift;
                lo_nxt = {lo[W-2:0], 1'b0};
            end
        end else begin
            hi_nxt = {1'b0, mul_sum[W:1]};
            lo_nxt = {mul_sum[0], lo[W-1:1]};
        end
    end

    // Sign correction and overflow of the finished magnitude result
    always_comb begin
        prod     = {hi[W-1:0], lo};
        prod_fix = neg_q ? -prod : prod;
        mul_ovf  = sgn_mode ? (prod_fix[2*W-1:W] != {W{prod_fix[W-1]}})
                            : (prod_fix[2*W-1:W] != '0);
        q_fix    = neg_q ? -lo : lo;
        r_fix    = neg_r ? -hi[W-1:0] : hi[W-1:0];
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                accept  = i_valid;
                if (i_valid && needs_iter) begin
                    state_nxt = ST_ITER;
                end
            end
            ST_ITER: begin
                if (cnt == '0) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture at accept, iterate, publish results
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_q      <= '0;
            o_r      <= '0;
            o_ovf    <= 1'b0;
            o_dbz    <= 1'b0;
            cnt      <= '0;
            op_div   <= 1'b0;
            sgn_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_dbz   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_div   <= (i_op == OP_DIV);
                        sgn_mode <= i_signed;
                        neg_q    <= i_signed && (i_a[W-1] ^ i_b[W-1]);
                        neg_r    <= i_signed && i_a[W-1];
                        mag_a    <= a_mag_in;
                        mag_b    <= b_mag_in;
                        hi       <= '0;
                        lo       <= (i_op == OP_DIV) ? a_mag_in[W-1:0] : b_mag_in[W-1:0];
                        cnt      <= CW'(W - 1);
                        case (i_op)
                            OP_ADD: begin
                                o_q     <= sum_ext[W-1:0];
                                o_r     <= '0;
                                o_ovf   <= add_ovf;
                                o_valid <= 1'b1;
                            end
                            OP_SUB: begin
                                o_q     <= diff_ext[W-1:0];
                                o_r     <= '0;
                                o_ovf   <= sub_ovf;
                                o_valid <= 1'b1;
                            end
                            OP_DIV: begin
                                if (early_dbz) begin
                                    o_q     <= '0;
                                    o_r     <= i_a;
                                    o_dbz   <= 1'b1;
                                    o_valid <= 1'b1;
                                end else if (early_ovf) begin
                                    o_q     <= MIN_VAL;
                                    o_r     <= '0;
                                    o_ovf   <= 1'b1;
                                    o_valid <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ITER: begin
                    hi <= hi_nxt;
                    lo <= lo_nxt;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    o_valid <= 1'b1;
                    if (op_div) begin
                        o_q <= q_fix;
                        o_r <= r_fix;
                    end else begin
                        o_q   <= prod_fix[W-1:0];
                        o_r   <= prod_fix[2*W-1:W];
                        o_ovf <= mul_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_alu_hs.sv
// Bench for sequential_alu_hs: three instances (W=4, 8, 16) checked every
// cycle against an arithmetic reference model, plus directed W=8 cases.
module tb_sequential_alu_hs;

    localparam int WI[3] = '{4, 8, 16};

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    logic        clk;
    logic        rst;
    logic        v_in [3];
    logic [1:0]  op_in [3];
    logic        sg_in [3];
    logic [63:0] a_in [3];
    logic [63:0] b_in [3];

    logic        rdy [3];
    logic        vld [3];
    logic        ovf [3];
    logic        dbz [3];
    wire  [3:0]  q0, r0;
    wire  [7:0]  q1, r1;
    wire  [15:0] q2, r2;
    logic [63:0] d_q [3];
    logic [63:0] d_r [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          cd [3];
    logic        e_valid [3];
    logic [63:0] e_q [3];
    logic [63:0] e_r [3];
    logic        e_ovf [3];
    logic        e_dbz [3];
    logic [63:0] p_q [3];
    logic [63:0] p_r [3];
    logic        p_ovf [3];
    logic        p_dbz [3];
    logic        acc_ev [3];

    sequential_alu_hs #(.DATA_WIDTH(4)) u_w4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[0]), .o_ready(rdy[0]),
        .i_op(op_in[0]), .i_signed(sg_in[0]), .i_a(a_in[0][3:0]), .i_b(b_in[0][3:0]),
        .o_valid(vld[0]), .o_q(q0), .o_r(r0), .o_ovf(ovf[0]), .o_dbz(dbz[0]));

    sequential_alu_hs #(.DATA_WIDTH(8)) u_w8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[1]), .o_ready(rdy[1]),
        .i_op(op_in[1]), .i_signed(sg_in[1]), .i_a(a_in[1][7:0]), .i_b(b_in[1][7:0]),
        .o_valid(vld[1]), .o_q(q1), .o_r(r1), .o_ovf(ovf[1]), .o_dbz(dbz[1]));

    sequential_alu_hs #(.DATA_WIDTH(16)) u_w16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v_in[2]), .o_ready(rdy[2]),
        .i_op(op_in[2]), .i_signed(sg_in[2]), .i_a(a_in[2][15:0]), .i_b(b_in[2][15:0]),
        .o_valid(vld[2]), .o_q(q2), .o_r(r2), .o_ovf(ovf[2]), .o_dbz(dbz[2]));

    always_comb begin
        d_q[0] = 64'(q0);
        d_r[0] = 64'(r0);
        d_q[1] = 64'(q1);
        d_r[1] = 64'(r1);
        d_q[2] = 64'(q2);
        d_r[2] = 64'(r2);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int w, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s w=%0d got=0x%0h want=0x%0h at %0t", nm, w, act, exp, $time);
        end
    endtask

    // Arithmetic reference: true-valued result, then range test and truncation
    function automatic void ref_op(input int w, input logic [1:0] op, input logic sg,
                                   input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] q, output logic [63:0] r,
                                   output logic o_ov, output logic o_dz, output logic fast);
        longint mask, sa, sb, res, lo_lim, hi_lim;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sg && sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (sg && sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        lo_lim = sg ? -(longint'(1) << (w - 1)) : 0;
        hi_lim = sg ? (longint'(1) << (w - 1)) - 1 : mask;
        q = '0; r = '0; o_ov = 1'b0; o_dz = 1'b0; fast = 1'b1;
        case (op)
            2'b00: begin
                res = sa + sb;
                q = res & mask;
                o_ov = (res < lo_lim) || (res > hi_lim);
            end
            2'b01: begin
                res = sa - sb;
                q = res & mask;
                o_ov = (res < lo_lim) || (res > hi_lim);
            end
            2'b10: begin
                res = sa * sb;
                q = res & mask;
                r = (res >>> w) & mask;
                o_ov = (res < lo_lim) || (res > hi_lim);
                fast = 1'b0;
            end
            default: begin
                if (sb == 0) begin
                    o_dz = 1'b1;
                    r = longint'(a) & mask;
                end else if (sg && sa == lo_lim && sb == -1) begin
                    o_ov = 1'b1;
                    q = (longint'(1) << (w - 1)) & mask;
                end else begin
                    q = (sa / sb) & mask;
                    r = (sa % sb) & mask;
                    fast = 1'b0;
                end
            end
        endcase
    endfunction

    // Cycle model: a slow op occupies the unit for W+1 edges after accept
    always @(posedge clk or posedge rst) begin : model
        logic [63:0] tq, tr;
        logic tov, tdz, tfast;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cd[i] <= 0;
                e_valid[i] <= 1'b0;
                e_q[i] <= '0;
                e_r[i] <= '0;
                e_ovf[i] <= 1'b0;
                e_dbz[i] <= 1'b0;
                acc_ev[i] <= 1'b0;
            end else begin
                e_valid[i] <= 1'b0;
                e_ovf[i] <= 1'b0;
                e_dbz[i] <= 1'b0;
                acc_ev[i] <= 1'b0;
                if (cd[i] != 0) begin
                    cd[i] <= cd[i] - 1;
                    if (cd[i] == 1) begin
                        e_valid[i] <= 1'b1;
                        e_q[i] <= p_q[i];
                        e_r[i] <= p_r[i];
                        e_ovf[i] <= p_ovf[i];
                        e_dbz[i] <= p_dbz[i];
                    end
                end else if (v_in[i]) begin
                    acc_ev[i] <= 1'b1;
                    ref_op(WI[i], op_in[i], sg_in[i], a_in[i], b_in[i], tq, tr, tov, tdz, tfast);
                    if (tfast) begin
                        e_valid[i] <= 1'b1;
                        e_q[i] <= tq;
                        e_r[i] <= tr;
                        e_ovf[i] <= tov;
                        e_dbz[i] <= tdz;
                    end else begin
                        cd[i] <= WI[i] + 1;
                        p_q[i] <= tq;
                        p_r[i] <= tr;
                        p_ovf[i] <= tov;
                        p_dbz[i] <= tdz;
                    end
                end
            end
        end
    end

    // Compare every output of every instance on every falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check("ready", WI[i], 64'(rdy[i]), 64'(cd[i] == 0));
            check("valid", WI[i], 64'(vld[i]), 64'(e_valid[i]));
            check("ovf",   WI[i], 64'(ovf[i]), 64'(e_ovf[i]));
            check("dbz",   WI[i], 64'(dbz[i]), 64'(e_dbz[i]));
            check("q",     WI[i], d_q[i], e_q[i]);
            check("r",     WI[i], d_r[i], e_r[i]);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input int i, input logic [1:0] op, input logic sg,
                         input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        v_in[i] = 1'b1;
        op_in[i] = op;
        sg_in[i] = sg;
        a_in[i] = a;
        b_in[i] = b;
        do begin
            @(negedge clk);
            n++;
        end while (!acc_ev[i] && n < 300);
        check("accept", WI[i], 64'(acc_ev[i]), 64'd1);
    endtask

    task automatic run8(input string nm, input logic [1:0] op, input logic sg,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic eov, input logic edz, input int elat, input int elow);
        int k, low;
        issue(1, op, sg, 64'(a), 64'(b));
        v_in[1] = 1'b0;
        k = 0;
        low = 0;
        while (!vld[1] && k < 40) begin
            if (!rdy[1]) low++;
            @(negedge clk);
            k++;
        end
        check({nm, "_lat"}, 8, 64'(k), 64'(elat));
        check({nm, "_ready_low"}, 8, 64'(low), 64'(elow));
        check({nm, "_q"}, 8, d_q[1], 64'(eq));
        check({nm, "_r"}, 8, d_r[1], 64'(er));
        check({nm, "_ovf"}, 8, 64'(ovf[1]), 64'(eov));
        check({nm, "_dbz"}, 8, 64'(dbz[1]), 64'(edz));
    endtask

    function automatic logic [63:0] rnd_opnd(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1 << (w - 1);
            2: return m;
            3: return (64'd1 << (w - 1)) - 64'd1;
            4: return 64'd1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    task automatic rand_run(input int i, input int n);
        for (int t = 0; t < n; t++) begin
            issue(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_opnd(WI[i]), rnd_opnd(WI[i]));
            if ($urandom_range(0, 2) == 0) begin
                v_in[i] = 1'b0;
                op_in[i] = 2'($urandom_range(0, 3));
                a_in[i] = {$urandom, $urandom};
                b_in[i] = {$urandom, $urandom};
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        v_in[i] = 1'b0;
    endtask

    initial begin : stim
        logic [63:0] mq, mr;
        logic mov, mdz, mf;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v_in[i] = 1'b0;
            op_in[i] = ADD;
            sg_in[i] = 1'b0;
            a_in[i] = '0;
            b_in[i] = '0;
        end

        // Pin the reference model against hand-computed values
        ref_op(8, ADD, 1'b1, 64'd100, 64'd100, mq, mr, mov, mdz, mf);
        check("model_sadd_q", 8, mq, 64'hC8);
        check("model_sadd_ovf", 8, 64'(mov), 64'd1);
        ref_op(8, MUL, 1'b1, 64'hF9, 64'd6, mq, mr, mov, mdz, mf);
        check("model_smul_q", 8, mq, 64'hD6);
        check("model_smul_r", 8, mr, 64'hFF);
        ref_op(8, DIV, 1'b1, 64'hF9, 64'd2, mq, mr, mov, mdz, mf);
        check("model_sdiv_q", 8, mq, 64'hFD);
        check("model_sdiv_r", 8, mr, 64'hFF);
        ref_op(8, DIV, 1'b0, 64'd250, 64'd7, mq, mr, mov, mdz, mf);
        check("model_udiv_q", 8, mq, 64'd35);
        check("model_udiv_r", 8, mr, 64'd5);

        repeat (3) @(negedge clk);
        check("rst_ready", 8, 64'(rdy[1]), 64'd1);
        check("rst_q", 8, d_q[1], 64'd0);
        rst = 1'b0;
        @(negedge clk);

        //   name      op   sg    a      b      q      r     ovf   dbz  lat low
        run8("sadd",   ADD, 1'b1, 8'd100, 8'd100, 8'hC8, 8'h00, 1'b1, 1'b0, 0, 0);
        run8("uadd",   ADD, 1'b0, 8'd200, 8'd100, 8'h2C, 8'h00, 1'b1, 1'b0, 0, 0);
        run8("smul",   MUL, 1'b1, 8'hF9,  8'd6,   8'hD6, 8'hFF, 1'b0, 1'b0, 9, 9);
        run8("umul",   MUL, 1'b0, 8'd16,  8'd16,  8'h00, 8'h01, 1'b1, 1'b0, 9, 9);
        run8("sdiv",   DIV, 1'b1, 8'hF9,  8'd2,   8'hFD, 8'hFF, 1'b0, 1'b0, 9, 9);
        run8("udiv",   DIV, 1'b0, 8'd250, 8'd7,   8'd35, 8'd5,  1'b0, 1'b0, 9, 9);
        run8("dbz",    DIV, 1'b0, 8'd5,   8'd0,   8'h00, 8'h05, 1'b0, 1'b1, 0, 0);
        run8("minm1",  DIV, 1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b1, 1'b0, 0, 0);
        run8("ssub",   SUB, 1'b1, 8'h80,  8'h01,  8'h7F, 8'h00, 1'b1, 1'b0, 0, 0);
        run8("usub",   SUB, 1'b0, 8'd3,   8'd5,   8'hFE, 8'h00, 1'b1, 1'b0, 0, 0);

        // Held request during a multiply is taken only once o_ready returns
        begin : hold_test
            int k;
            issue(1, MUL, 1'b0, 64'd3, 64'd5);
            op_in[1] = ADD;
            a_in[1] = 64'd3;
            b_in[1] = 64'd4;
            k = 0;
            while (!vld[1] && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("hold_mul_lat", 8, 64'(k), 64'd9);
            check("hold_mul_q", 8, d_q[1], 64'd15);
            check("hold_mul_ready", 8, 64'(rdy[1]), 64'd1);
            @(negedge clk);
            check("hold_add_valid", 8, 64'(vld[1]), 64'd1);
            check("hold_add_q", 8, d_q[1], 64'd7);
            v_in[1] = 1'b0;
            @(negedge clk);
        end

        // Reset in the middle of a divide
        issue(1, DIV, 1'b0, 64'd200, 64'd3);
        v_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 8, 64'(vld[1]), 64'd0);
        check("midrst_q", 8, d_q[1], 64'd0);
        check("midrst_r", 8, d_r[1], 64'd0);
        check("midrst_ready", 8, 64'(rdy[1]), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run8("post_rst_add", ADD, 1'b0, 8'd1, 8'd2, 8'd3, 8'd0, 1'b0, 1'b0, 0, 0);

        // Randomised sweep on all widths in parallel
        fork
            rand_run(0, 250);
            rand_run(1, 250);
            rand_run(2, 150);
        join
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sequential_alu_hs.md
# sequential_alu_hs

Parametrised multi-cycle integer ALU with a valid/ready input handshake. It supports add, subtract, multiply and divide in both signed and unsigned modes, and returns a full double-width result (product high half or division remainder). It is the next-generation drop-in arithmetic engine for datapaths that need backpressure, unsigned arithmetic and remainder/high-product outputs. Add/sub complete at the accepting edge; mul/div iterate one bit per clock.

## Interface
- DATA_WIDTH, 16, operand/result width in bits; legal range 4..64.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operation request; qualified by o_ready.
- o_ready  out  1  high only in IDLE; a request is accepted on an edge where i_valid & o_ready.
- i_op  in  2  00 add, 01 sub, 10 mul, 11 div; sampled at accept.
- i_signed  in  1  1 selects two's-complement, 0 selects unsigned; sampled at accept.
- i_a, i_b  in  DATA_WIDTH  operands; sampled at accept (a op b; for div, a is the dividend).
- o_valid  out  1  one-cycle pulse marking the result and flags as valid.
- o_q  out  DATA_WIDTH  sum, difference, low product half, or quotient.
- o_r  out  DATA_WIDTH  high product half, or remainder; 0 for add/sub.
- o_ovf  out  1  result does not fit in DATA_WIDTH bits in the selected mode.
- o_dbz  out  1  divide by zero.

## Operation
- States:
  - IDLE: sole state with o_ready=1. Add/sub and early-exit cases stay in IDLE.
  - ITER: mul/div, an internal bit counter runs from DATA_WIDTH-1 down to 0.
  - FIX: one cycle of sign correction and overflow evaluation, then return to IDLE.
- Add/sub: computed and registered at the accepting edge; o_r=0.
  - Signed mode: o_ovf = operand signs agree and the result sign differs (for sub, the sign of -b is used).
  - Unsigned mode: o_ovf = carry out (add) or borrow (sub).
- Mul/div, at accept: latch opcode and mode, latch operand magnitudes (|x| in signed mode, raw value in unsigned mode), latch negate flags, then enter ITER.
  - Magnitudes are held DATA_WIDTH+1 bits wide, so |MIN| is exact.
- Mul: shift-add, one multiplier bit per cycle, into a 2·DATA_WIDTH accumulator.
  - FIX negates the full product if sign(a)^sign(b).
  - o_q = low half, o_r = high half, always the exact 2W product.
  - o_ovf=1 if the product is outside the W-bit range of the mode.
- Div: restoring division, one quotient bit per cycle, MSB first.
  - Quotient truncates toward zero.
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of the dividend.
- Early exits, evaluated at accept, no ITER; o_valid on the next cycle:
  - Div with b=0: o_dbz=1, o_q=0, o_r=i_a, o_ovf=0.
  - Signed div MIN/-1: o_ovf=1, o_q=MIN, o_r=0.
- Requests are ignored while o_ready=0; there is no queueing.
- o_q/o_r hold their last value between results. o_ovf/o_dbz are meaningful only with o_valid and are 0 otherwise.

## Timing
- Reset values: o_valid=0, o_q=0, o_r=0, o_ovf=0, o_dbz=0, state IDLE, o_ready=1.
- Reset is asynchronous at any point, including mid-ITER. It aborts the operation with no o_valid; o_ready=1 the cycle after release.
- Edge numbering: E0 is the accepting edge.
- Add/sub and early exits: o_valid high in the cycle after E0; o_ready stays 1, so back-to-back accepts are allowed every cycle.
- Mul/div timing (W = DATA_WIDTH):
  - Edges E1..EW perform the iterations; E(W+1) performs FIX and sets o_valid.
  - o_valid is high in the cycle after E(W+1), and o_ready is high in the same cycle.
  - Latency is W+1 edges after accept; W+2 cycles from accept to the next accept.
- o_ready deasserts in the cycle after a mul/div accept and stays low through the FIX cycle.
- Input changes during ITER/FIX have no effect.

## Test plan
- W=8, signed add 100+100 -> o_q=0xC8, o_ovf=1, o_valid on the cycle after accept. Unsigned 200+100 -> o_q=0x2C, o_ovf=1.
- W=8, signed mul -7×6 -> o_q=0xD6, o_r=0xFF, o_ovf=0, o_valid 9 edges after accept, o_ready low for exactly 9 cycles. Unsigned 16×16 -> o_q=0x00, o_r=0x01, o_ovf=1.
- W=8, signed div -7/2 -> o_q=0xFD (-3), o_r=0xFF (-1). Unsigned 250/7 -> o_q=35, o_r=5.
- W=8, div 5/0 -> o_dbz=1, o_q=0, o_r=5, one-cycle latency. Signed 0x80/0xFF -> o_ovf=1, o_q=0x80.
- Hold i_valid with a new op throughout a mul -> no second accept until o_ready; the held op is then accepted on the o_valid cycle.
- Assert i_rst at E4 of a div -> all outputs return to reset values immediately, no o_valid; the next add after release completes normally.
- Randomised sweep at W=4, 8 and 16 against a reference model covering all ops and both modes, including MIN, -1, 0 and MAX operands.
